mem_arbiter_n: RTL and testbench
================================

Name: mem_arbiter_n

Overview:
Parametrised successor to the CPU's two-client memory interface. Arbitrates NUM_CH requesters onto the single byte-serial RAM/IO bus: 8-bit data, 1-cycle read latency, writes take effect in the same cycle. Each transfer is 1..4 bytes, little-endian. Supports round-robin arbitration, misbranch cancellation of speculative channels, IO-write back-pressure and rdy pausing. Sits between fetcher/i-cache/slbuffer and the cpu top-level bus pins.

Parameters:
NUM_CH, 3, number of requester channels (>=2)
FLUSH_MASK, 3'b011, bit i set: channel i's reads are speculative and cancelled by has_misbranch
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; 0 pauses block
has_misbranch  in  1  pipeline flush pulse
io_buffer_full  in  1  UART buffer full
ram_wr  out  1  1 = write this cycle
ram_addr  out  ADDR_W  bus address
out_ram_data  out  8  write byte
in_ram_data  in  8  read byte (for address presented previous cycle)
req_valid  in  NUM_CH  request held high until matching resp_valid
req_we  in  NUM_CH  1 = write
req_addr  in  NUM_CH*ADDR_W  start address, channel i at [i*ADDR_W +: ADDR_W]
req_bytes  in  NUM_CH*3  byte count 1..4 (0 and >4 illegal)
req_wdata  in  NUM_CH*32  write data, byte k at [8k+7:8k]
resp_valid  out  NUM_CH  one-cycle one-hot completion pulse
resp_data  out  32  read data, zero-extended above byte count
busy  out  1  transfer in progress (not IDLE)

Behaviour:
- All outputs registered. Reset: ram_wr=0, ram_addr=0, out_ram_data=0, resp_valid=0, resp_data=0, busy=0, FSM=IDLE, rr pointer=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: pick first channel with req_valid, scanning from rr pointer upward, modulo NUM_CH. Latch channel, we, addr, bytes and wdata. rr pointer <= granted+1 mod NUM_CH. Go to READ or WRITE. Grant edge = G.
- READ: address A+k is on the bus in cycle G+1+k, ram_wr=0. Byte k is sampled from in_ram_data at the end of cycle G+2+k. After the last address, ram_addr=0. After the last sample go to DONE. resp_valid[ch] and resp_data are visible in cycle G+n+2.
- WRITE: cycle G+1+k drives ram_wr=1, ram_addr=A+k, out_ram_data=byte k. After the last byte go to DONE. resp_valid is visible in cycle G+n+1.
- DONE: resp_valid held for exactly one cycle. No grant is made in this cycle. Next state is IDLE, so a channel's own held req_valid is never re-granted.
- Bus idle value: ram_wr=0, ram_addr=0.
- IO back-pressure: an IO write has ram_addr[17:16]==2'b11. If io_buffer_full=1 at the edge that would place an IO write byte on the bus, the bus goes idle for that cycle. The byte index does not advance, and the byte is retried each cycle until io_buffer_full=0. IO reads are unaffected.
- Misbranch: has_misbranch=1 at an edge with the FSM in READ on a FLUSH_MASK channel:
  - FSM goes to IDLE, bus goes idle, no resp is produced.
  - In IDLE, FLUSH_MASK channels are excluded from arbitration in that cycle.
  - A resp already in DONE for a flushable channel is suppressed (resp_valid stays 0).
  - WRITEs, and READs on non-flush channels, are never cancelled.
- rdy=0: no state or register changes, and the ram_wr output is gated to 0. Samples taken during rdy=0 are discarded. On the first rdy=1 cycle, an active READ re-issues from the first uncaptured byte, and sample timing restarts relative to that re-issue. A WRITE re-drives its current byte.
- rst mid-transfer: immediate return to reset values. The partial transfer is dropped and no resp is produced.
- Address arithmetic A+k wraps modulo 2^ADDR_W.

Test Plan:
1. rst high 2 cycles mid-WRITE -> the next cycle shows ram_wr=0, ram_addr=0, resp_valid=0, busy=0. No further bus writes.
2. ch0 4-byte read at A=0x100, mem[0x100..0x103]=11,22,33,44 -> ram_addr=0x100..0x103 in G+1..G+4; resp_valid=3'b001 in G+6 only; resp_data=0x44332211. A 2-byte read of the same address gives resp_data=0x00002211.
3. ch0 and ch1 continuously request 1-byte reads, rr=0 -> grant order ch0, ch1, ch0, ch1. Each DONE cycle has no bus activity.
4. ch2 1-byte write 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles from G -> ram_wr=0 during those cycles. ram_wr=1, ram_addr=0x30000, out_ram_data=0x41 appear the cycle after the write is released; resp_valid[2] follows one cycle later.
5. has_misbranch at G+2 of a ch0 4-byte read -> busy=0 next cycle, resp_valid[0] never asserts. Misbranch during a ch2 4-byte write of 0xDEADBEEF to 0x200 -> bytes EF, BE, AD, DE are all written and resp_valid[2] asserts.
6. rdy=0 for cycles G+2..G+3 of a ch1 4-byte read of 0x100 -> ram_wr=0 during the pause; resp_data=0x44332211; resp arrives 2 or more cycles later than in case 2.

Source files
------------

// File: rtl/mem_arbiter_n_if.sv
// Requester and RAM/IO bus bundle for mem_arbiter_n.
//   slave  : arbiter side (samples requests and read data, drives responses and bus)
//   master : environment side (requesters plus RAM/IO)
// Signals:
//   req_valid/req_we/req_addr/req_bytes/req_wdata : per-channel requests, flattened
//   resp_valid/resp_data/busy                      : completion pulse, read data, activity
//   ram_wr/ram_addr/out_ram_data/in_ram_data       : byte-serial RAM/IO bus
interface mem_arbiter_n_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 32
) ();
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*3-1:0]      req_bytes;
  logic [NUM_CH*32-1:0]     req_wdata;
  logic [NUM_CH-1:0]        resp_valid;
  logic [31:0]              resp_data;
  logic                     busy;
  logic                     ram_wr;
  logic [ADDR_W-1:0]        ram_addr;
  logic [7:0]               out_ram_data;
  logic [7:0]               in_ram_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_bytes, req_wdata, in_ram_data,
    output resp_valid, resp_data, busy, ram_wr, ram_addr, out_ram_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_bytes, req_wdata, in_ram_data,
    input  resp_valid, resp_data, busy, ram_wr, ram_addr, out_ram_data
  );
endinterface

// File: rtl/mem_arbiter_n.sv
// Round-robin arbiter of NUM_CH requesters onto a byte-serial RAM/IO bus
// (8-bit data, 1-cycle read latency, same-cycle writes, 1..4 byte LE transfers).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global ready, 0 freezes the block and gates ram_wr
//   has_misbranch   : flush pulse, cancels speculative (FLUSH_MASK) reads
//   io_buffer_full  : stalls IO writes (ram_addr[17:16] == 2'b11)
//   bus             : requester handshake and RAM/IO bus (mem_arbiter_n_if.slave)
module mem_arbiter_n #(
  parameter int                NUM_CH     = 3,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = 3'b011,
  parameter int                ADDR_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           has_misbranch,
  input  logic           io_buffer_full,
  mem_arbiter_n_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  typedef logic [CH_W-1:0] ch_t;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  ch_t               rr, ch;
  logic              we;
  logic [ADDR_W-1:0] base;
  logic [2:0]        nbytes;
  logic [31:0]       wdata, rdata;
  logic [2:0]        ai;        // next byte to put on the bus
  logic [2:0]        si;        // next read byte to capture
  logic              p1, p2;    // read address on bus now / its data arriving now
  logic              paused;    // previous edge saw rdy=0
  logic              ram_wr_q, busy_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [7:0]        wr_byte_q;
  logic [NUM_CH-1:0] resp_q;
  logic [31:0]       resp_data_q;

  logic [NUM_CH-1:0] eligible, ch_onehot;
  logic              grant_found;
  ch_t               grant_idx;
  int                scan;
  logic [31:0]       merged;
  logic [ADDR_W-1:0] cur_addr, resume_addr;
  logic              io_stall;

  // Round-robin scan starting at rr; speculative channels sit out a flush cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    eligible    = bus.req_valid & ~(has_misbranch ? FLUSH_MASK : '0);
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan = int'(rr) + i;
      if (scan >= NUM_CH) scan = scan - NUM_CH;
      if (!grant_found && eligible[scan]) begin
        grant_found = 1'b1;
        grant_idx   = ch_t'(scan);
      end
    end
  end

  always_comb begin
    merged = rdata;
    merged[{si[1:0], 3'b000} +: 8] = bus.in_ram_data;
  end

  assign ch_onehot   = {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
  assign cur_addr    = base + ADDR_W'(ai);
  assign resume_addr = base + ADDR_W'(si);
  assign io_stall    = (cur_addr[17:16] == 2'b11) && io_buffer_full;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
    if (rst) begin
      state       <= IDLE;
      rr          <= '0;
      ch          <= '0;
      we          <= 1'b0;
      base        <= '0;
      nbytes      <= '0;
      wdata       <= '0;
      rdata       <= '0;
      ai          <= '0;
      si          <= '0;
      p1          <= 1'b0;
      p2          <= 1'b0;
      paused      <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      wr_byte_q   <= '0;
      resp_q      <= '0;
      resp_data_q <= '0;
      busy_q      <= 1'b0;
    end else if (!rdy) begin
      paused <= 1'b1;
    end else begin
      paused <= 1'b0;
      unique case (state)
        IDLE: begin
          ram_wr_q   <= 1'b0;
          ram_addr_q <= '0;
          resp_q     <= '0;
          if (grant_found) begin
            ch     <= grant_idx;
            we     <= bus.req_we[grant_idx];
            base   <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
            nbytes <= bus.req_bytes[grant_idx*3 +: 3];
            wdata  <= bus.req_wdata[grant_idx*32 +: 32];
            rr     <= (grant_idx == ch_t'(NUM_CH - 1)) ? '0 : grant_idx + ch_t'(1);
            ai     <= '0;
            si     <= '0;
            p1     <= 1'b0;
            p2     <= 1'b0;
            rdata  <= '0;
            busy_q <= 1'b1;
            state  <= bus.req_we[grant_idx] ? WRITE : READ;
          end
        end
        READ: begin
          if (has_misbranch && FLUSH_MASK[ch]) begin
            ram_addr_q <= '0;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end else if (paused) begin
            // Samples seen during the pause were dropped; restart the pipe
            // at the first byte not yet captured.
            ram_addr_q <= resume_addr;
            ai         <= si + 3'd1;
            p1         <= 1'b1;
            p2         <= 1'b0;
          end else begin
            p2 <= p1;
            if (ai < nbytes) begin
              ram_addr_q <= cur_addr;
              ai         <= ai + 3'd1;
              p1         <= 1'b1;
            end else begin
              ram_addr_q <= '0;
              p1         <= 1'b0;
            end
            if (p2) begin
              rdata <= merged;
              si    <= si + 3'd1;
              if (si == nbytes - 3'd1) begin
                resp_q      <= ch_onehot;
                resp_data_q <= merged;
                state       <= DONE;
              end
            end
          end
        end
        WRITE: begin
          if (paused && ram_wr_q) begin
            // The byte on the bus was gated off by rdy; leave it up one more cycle.
          end else if (ai < nbytes) begin
            if (io_stall) begin
              ram_wr_q   <= 1'b0;
              ram_addr_q <= '0;
            end else begin
              ram_wr_q   <= 1'b1;
              ram_addr_q <= cur_addr;
              wr_byte_q  <= wdata[{ai[1:0], 3'b000} +: 8];
              ai         <= ai + 3'd1;
            end
          end else begin
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            resp_q      <= ch_onehot;
            resp_data_q <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          resp_q <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ram_wr       = ram_wr_q & rdy;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.out_ram_data = wr_byte_q;
  // A flush arriving while a speculative read sits in DONE withdraws its pulse.
  assign bus.resp_valid   = resp_q & ~({NUM_CH{has_misbranch}} & FLUSH_MASK);
  assign bus.resp_data    = resp_data_q;
  assign bus.busy         = busy_q;

  logic unused_we;
  assign unused_we = we;
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Self-checking bench for mem_arbiter_n: directed requests, a byte RAM model,
// and a scoreboard of expected responses popped by an independent monitor.
module tb_mem_arbiter_n;
  logic clk = 1'b0;
  logic rst, rdy, has_misbranch, io_buffer_full;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_n_if #(.NUM_CH(3), .ADDR_W(32)) bus ();

  mem_arbiter_n #(.NUM_CH(3), .FLUSH_MASK(3'b011), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
    .io_buffer_full(io_buffer_full), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ch;
    logic [31:0] data;
    int          at;        // expected cycle, -1 = not checked
    bit          chk_data;
  } exp_t;

  exp_t        sb[$];
  logic [39:0] wlog[$];
  logic [7:0]  mem[logic [31:0]];
  logic [31:0] prev_addr = '0;
  int          resp_cyc = 0;
  int          resp_seen[3] = '{0, 0, 0};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // RAM/IO model: write on ram_wr, return the byte for last cycle's address.
  always @(negedge clk) begin
    if (bus.ram_wr) begin
      mem[bus.ram_addr] = bus.out_ram_data;
      wlog.push_back({bus.ram_addr, bus.out_ram_data});
    end
    bus.in_ram_data = mem.exists(prev_addr) ? mem[prev_addr] : 8'h00;
    prev_addr = bus.ram_addr;
  end

  // Response monitor.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.resp_valid != '0) begin
      resp_cyc = cyc;
      for (int i = 0; i < 3; i++) if (bus.resp_valid[i]) resp_seen[i]++;
      check("done_bus_idle", {bus.ram_wr, bus.ram_addr}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_resp", bus.resp_valid, 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_valid", bus.resp_valid, 64'd1 << e.ch);
        if (e.chk_data) check("resp_data", bus.resp_data, e.data);
        if (e.at >= 0) check("resp_cycle", cyc, e.at);
      end
    end
  end

  task automatic push(input int ch, input logic [31:0] data, input int at, input bit chk);
    exp_t e;
    e.ch = ch; e.data = data; e.at = at; e.chk_data = chk;
    sb.push_back(e);
  endtask

  task automatic set_req(input int ch, input bit w, input logic [31:0] a,
                         input logic [2:0] n, input logic [31:0] d);
    bus.req_we[ch]           = w;
    bus.req_addr[ch*32 +: 32] = a;
    bus.req_bytes[ch*3 +: 3]  = n;
    bus.req_wdata[ch*32 +: 32] = d;
    bus.req_valid[ch]        = 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_resp(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, sb.size(), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g;
    int          seen0;
    logic [31:0] exp_w;

    rst = 1'b1; rdy = 1'b1; has_misbranch = 1'b0; io_buffer_full = 1'b0;
    bus.req_valid = '0; bus.req_we = '0; bus.req_addr = '0;
    bus.req_bytes = '0; bus.req_wdata = '0; bus.in_ram_data = '0;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22;
    mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ram_wr", bus.ram_wr, 64'd0);
    check("rst_ram_addr", bus.ram_addr, 64'd0);
    check("rst_out_data", bus.out_ram_data, 64'd0);
    check("rst_resp", {bus.resp_valid, bus.resp_data}, 64'd0);
    check("rst_busy", bus.busy, 64'd0);
    rst = 1'b0;

    // 1: reset in the middle of a 4-byte write
    @(negedge clk);
    wlog.delete();
    g = cyc + 1;
    set_req(0, 1'b1, 32'h400, 3'd4, 32'h04030201);
    wait_until(g + 2);
    rst = 1'b1;
    bus.req_valid[0] = 1'b0;
    wait_until(g + 3);
    check("t1_ram_wr", bus.ram_wr, 64'd0);
    check("t1_ram_addr", bus.ram_addr, 64'd0);
    check("t1_resp", bus.resp_valid, 64'd0);
    check("t1_busy", bus.busy, 64'd0);
    wait_until(g + 4);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_write_count", wlog.size(), 64'd2);
    if (wlog.size() >= 2) begin
      check("t1_write0", wlog[0], {32'h400, 8'h01});
      check("t1_write1", wlog[1], {32'h401, 8'h02});
    end

    // 3: ch0 and ch1 both requesting, rr starts at 0
    set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
    set_req(1, 1'b0, 32'h101, 3'd1, 32'h0);
    push(0, 32'h11, -1, 1'b1);
    push(1, 32'h22, -1, 1'b1);
    push(0, 32'h11, -1, 1'b1);
    push(1, 32'h22, -1, 1'b1);
    wait_resp("t3", 40);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // 2: 4-byte read then 2-byte read on ch0
    g = cyc + 1;
    set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    push(0, 32'h44332211, g + 6, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_until(g + 1 + k);
      check("t2_addr", bus.ram_addr, 32'h100 + k);
      check("t2_rd", bus.ram_wr, 64'd0);
    end
    wait_resp("t2", 20);
    bus.req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    g = cyc + 1;
    set_req(0, 1'b0, 32'h100, 3'd2, 32'h0);
    push(0, 32'h00002211, g + 4, 1'b1);
    wait_resp("t2b", 20);
    bus.req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);

    // 4: IO write held off by io_buffer_full for 3 cycles
    g = cyc + 1;
    set_req(2, 1'b1, 32'h30000, 3'd1, 32'h41);
    push(2, 32'h0, g + 5, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_until(g + k);
      if (k == 0) io_buffer_full = 1'b1;
      check("t4_stalled", bus.ram_wr, 64'd0);
    end
    io_buffer_full = 1'b0;
    wait_until(g + 4);
    check("t4_io_write", {bus.ram_wr, bus.ram_addr, bus.out_ram_data}, {1'b1, 32'h30000, 8'h41});
    wait_resp("t4", 20);
    bus.req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);

    // 5a: misbranch cancels a speculative ch0 read
    seen0 = resp_seen[0];
    g = cyc + 1;
    set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
    wait_until(g + 2);
    has_misbranch = 1'b1;
    bus.req_valid[0] = 1'b0;
    wait_until(g + 3);
    has_misbranch = 1'b0;
    check("t5_busy", bus.busy, 64'd0);
    repeat (8) @(negedge clk);
    check("t5_no_resp", resp_seen[0], seen0);

    // 5b: misbranch during a ch2 write has no effect
    wlog.delete();
    exp_w = 32'hDEADBEEF;
    g = cyc + 1;
    set_req(2, 1'b1, 32'h200, 3'd4, exp_w);
    push(2, 32'h0, g + 5, 1'b0);
    wait_until(g + 2);
    has_misbranch = 1'b1;
    wait_until(g + 3);
    has_misbranch = 1'b0;
    wait_resp("t5b", 20);
    bus.req_valid[2] = 1'b0;
    check("t5b_write_count", wlog.size(), 64'd4);
    for (int k = 0; k < 4 && k < wlog.size(); k++)
      check("t5b_write", wlog[k], {32'h200 + k, exp_w[8*k +: 8]});
    repeat (3) @(negedge clk);

    // 6: rdy pause in the middle of a ch1 read
    g = cyc + 1;
    set_req(1, 1'b0, 32'h100, 3'd4, 32'h0);
    push(1, 32'h44332211, -1, 1'b1);
    wait_until(g + 2);
    rdy = 1'b0;
    wait_until(g + 3);
    check("t6_pause_wr", bus.ram_wr, 64'd0);
    check("t6_pause_busy", bus.busy, 64'd1);
    wait_until(g + 4);
    check("t6_pause_wr2", bus.ram_wr, 64'd0);
    rdy = 1'b1;
    wait_resp("t6", 30);
    bus.req_valid[1] = 1'b0;
    check("t6_late", (resp_cyc - g) >= 8, 64'd1);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
